board_writer: RTL and testbench

- Write-side counterpart of the 9:1 cell-read mux. Holds the 3x3 tic-tac-toe board as nine WIDTH-bit cell registers, one per square, and drives them onto cell1..cell9. These outputs feed the mux in1..in9 inputs directly.
- Accepts move requests through a valid/ready handshake and validates each one (range, occupancy, turn order). Accepted moves are written into the selected cell, and every request gets exactly one response.

---
 rtl/board_writer.sv | 136 +++++++++++++
 tb/tb_board_writer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_writer.sv
// Write side of the tic-tac-toe board: validates move requests through a
// valid/ready handshake and stores accepted moves in nine registered cells.
module board_writer #(
  parameter int WIDTH  = 16,
  parameter int X_CODE = 1,
  parameter int O_CODE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_sel,
  input  logic             req_player,
  output logic             resp_valid,
  output logic [2:0]       resp_code,
  output logic [WIDTH-1:0] cell1,
  output logic [WIDTH-1:0] cell2,
  output logic [WIDTH-1:0] cell3,
  output logic [WIDTH-1:0] cell4,
  output logic [WIDTH-1:0] cell5,
  output logic [WIDTH-1:0] cell6,
  output logic [WIDTH-1:0] cell7,
  output logic [WIDTH-1:0] cell8,
  output logic [WIDTH-1:0] cell9,
  output logic             turn,
  output logic [3:0]       move_count,
  output logic             board_full
);

  localparam logic [WIDTH-1:0] L_X = WIDTH'(X_CODE);
  localparam logic [WIDTH-1:0] L_O = WIDTH'(O_CODE);

  localparam logic [2:0] C_OK    = 3'd0;
  localparam logic [2:0] C_RANGE = 3'd1;
  localparam logic [2:0] C_OCC   = 3'd2;
  localparam logic [2:0] C_TURN  = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITE, S_RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_sel;
  logic             r_player;
  logic [WIDTH-1:0] r_cell [9];
  logic             r_turn;
  logic [3:0]       r_count;
  logic [2:0]       r_code;
  logic [WIDTH-1:0] w_target;
  logic [2:0]       w_err;
  logic             w_sync_rst;

  // clear behaves exactly like reset; both drop any in-flight request silently
  assign w_sync_rst = !rst_n || clear;

  always_ff @(posedge clk) begin
    if (w_sync_rst) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = S_CHECK;
      S_CHECK: w_next = (w_err != C_OK) ? S_RESP : S_WRITE;
      S_WRITE: w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == S_IDLE);
    resp_valid = (r_state == S_RESP);
  end

  // Out-of-range selects read as empty; RANGE outranks OCCUPIED anyway
  always_comb begin
    w_target = '0;
    for (int i = 0; i < 9; i++)
      if (r_sel == 4'(i)) w_target = r_cell[i];
  end

  always_comb begin
    if (r_sel > 4'd8)           w_err = C_RANGE;
    else if (w_target != '0)    w_err = C_OCC;
    else if (r_player != r_turn) w_err = C_TURN;
    else                        w_err = C_OK;
  end

  always_ff @(posedge clk) begin
    if (w_sync_rst) begin
      for (int i = 0; i < 9; i++) r_cell[i] <= '0;
      r_turn   <= 1'b0;
      r_count  <= 4'd0;
      r_code   <= C_OK;
      r_sel    <= 4'd0;
      r_player <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_sel    <= req_sel;
            r_player <= req_player;
          end
        end
        S_CHECK: begin
          if (w_err != C_OK) r_code <= w_err;
        end
        S_WRITE: begin
          for (int i = 0; i < 9; i++)
            if (r_sel == 4'(i)) r_cell[i] <= r_player ? L_O : L_X;
          r_count <= r_count + 4'd1;
          r_turn  <= ~r_turn;
          r_code  <= C_OK;
        end
        default: ;
      endcase
    end
  end

  assign resp_code  = r_code;
  assign turn       = r_turn;
  assign move_count = r_count;
  assign board_full = (r_count == 4'd9);
  assign cell1 = r_cell[0];
  assign cell2 = r_cell[1];
  assign cell3 = r_cell[2];
  assign cell4 = r_cell[3];
  assign cell5 = r_cell[4];
  assign cell6 = r_cell[5];
  assign cell7 = r_cell[6];
  assign cell8 = r_cell[7];
  assign cell9 = r_cell[8];

endmodule

// File: tb/tb_board_writer.sv
// Self-checking bench for board_writer: directed scenarios plus random moves
// compared against a plain board/turn/count model of the game rules.
module tb_board_writer;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [3:0]       req_sel = 4'd0;
  logic             req_player = 1'b0;
  logic             resp_valid;
  logic [2:0]       resp_code;
  logic [WIDTH-1:0] cell1, cell2, cell3, cell4, cell5, cell6, cell7, cell8, cell9;
  logic             turn;
  logic [3:0]       move_count;
  logic             board_full;

  int checks = 0;
  int errors = 0;

  int mb [9];
  int mturn;
  int mcount;

  board_writer #(.WIDTH(WIDTH), .X_CODE(1), .O_CODE(2)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_player(req_player),
    .resp_valid(resp_valid), .resp_code(resp_code),
    .cell1(cell1), .cell2(cell2), .cell3(cell3), .cell4(cell4), .cell5(cell5),
    .cell6(cell6), .cell7(cell7), .cell8(cell8), .cell9(cell9),
    .turn(turn), .move_count(move_count), .board_full(board_full)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] dut_cell(int i);
    case (i)
      0: return cell1;
      1: return cell2;
      2: return cell3;
      3: return cell4;
      4: return cell5;
      5: return cell6;
      6: return cell7;
      7: return cell8;
      default: return cell9;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 9; i++) mb[i] = 0;
    mturn = 0;
    mcount = 0;
  endfunction

  function automatic int model_code(int sel, int pl);
    if (sel > 8) return 1;
    if (mb[sel] != 0) return 2;
    if (pl != mturn) return 3;
    return 0;
  endfunction

  function automatic void model_apply(int sel, int pl);
    mb[sel] = (pl != 0) ? 2 : 1;
    mturn = 1 - mturn;
    mcount++;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Issues one request; lat counts negedges after the accept edge until resp_valid
  // (0 when none arrives), extra reports resp_valid one cycle after the pulse.
  task automatic do_request(input logic [3:0] sel, input logic pl,
                            output logic [2:0] code, output int lat, output logic extra);
    @(negedge clk);
    req_valid = 1'b1;
    req_sel = sel;
    req_player = pl;
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    code = 3'bxxx;
    extra = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      if (resp_valid) begin
        lat = k;
        code = resp_code;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    extra = resp_valid;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (dut_cell(i) !== '0) begin
        errors++;
        $display("FAIL reset_cell%0d: got %0d expected 0", i + 1, dut_cell(i));
      end
    end
    checks++;
    if ({turn, move_count, board_full, resp_valid, resp_code} !== 10'd0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: turn=%0d cnt=%0d full=%0d rv=%0d rc=%0d rdy=%0d expected 0,0,0,0,0,1",
               turn, move_count, board_full, resp_valid, resp_code, req_ready);
    end
  endtask

  task automatic test_center();
    logic [2:0] code; int lat; logic extra;
    do_reset();
    do_request(4'd4, 1'b0, code, lat, extra);
    model_apply(4, 0);
    checks++;
    if (code !== 3'd0 || lat != 3) begin
      errors++;
      $display("FAIL center_ok: code=%0d lat=%0d expected 0 lat 3", code, lat);
    end
    checks++;
    if (cell5 !== 16'd1 || turn !== 1'b1 || move_count !== 4'd1) begin
      errors++;
      $display("FAIL center_state: cell5=%0d turn=%0d cnt=%0d expected 1,1,1", cell5, turn, move_count);
    end
    checks++;
    if (extra !== 1'b0) begin
      errors++;
      $display("FAIL center_pulse: resp_valid second cycle=%0d expected 0", extra);
    end
    do_request(4'd4, 1'b1, code, lat, extra);
    checks++;
    if (code !== 3'd2 || lat != 2) begin
      errors++;
      $display("FAIL center_occupied: code=%0d lat=%0d expected 2 lat 2", code, lat);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (dut_cell(i) !== WIDTH'(mb[i])) begin
        errors++;
        $display("FAIL center_board%0d: got %0d expected %0d", i + 1, dut_cell(i), mb[i]);
      end
    end
    checks++;
    if (turn !== 1'b1 || move_count !== 4'd1) begin
      errors++;
      $display("FAIL center_unchanged: turn=%0d cnt=%0d expected 1,1", turn, move_count);
    end
  endtask

  task automatic test_errors();
    logic [2:0] code; int lat; logic extra;
    do_reset();
    do_request(4'd9, 1'b0, code, lat, extra);
    checks++;
    if (code !== 3'd1 || lat != 2 || extra !== 1'b0) begin
      errors++;
      $display("FAIL err_range: code=%0d lat=%0d extra=%0d expected 1 lat 2 extra 0", code, lat, extra);
    end
    checks++;
    if ({cell1, cell2, cell3, cell4, cell5, cell6, cell7, cell8, cell9} !== '0 || move_count !== 4'd0) begin
      errors++;
      $display("FAIL err_range_board: cnt=%0d expected empty board, cnt 0", move_count);
    end
    do_reset();
    do_request(4'd0, 1'b1, code, lat, extra);
    checks++;
    if (code !== 3'd3 || lat != 2) begin
      errors++;
      $display("FAIL err_turn: code=%0d lat=%0d expected 3 lat 2", code, lat);
    end
    checks++;
    if (cell1 !== '0 || turn !== 1'b0) begin
      errors++;
      $display("FAIL err_turn_state: cell1=%0d turn=%0d expected 0,0", cell1, turn);
    end
  endtask

  task automatic test_fill();
    logic [2:0] code; int lat; logic extra;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      do_request(4'(i), 1'(i % 2), code, lat, extra);
      checks++;
      if (code !== 3'd0 || lat != 3) begin
        errors++;
        $display("FAIL fill_move%0d: code=%0d lat=%0d expected 0 lat 3", i, code, lat);
      end
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (dut_cell(i) !== WIDTH'((i % 2) + 1)) begin
        errors++;
        $display("FAIL fill_cell%0d: got %0d expected %0d", i + 1, dut_cell(i), (i % 2) + 1);
      end
    end
    checks++;
    if (move_count !== 4'd9 || board_full !== 1'b1) begin
      errors++;
      $display("FAIL fill_full: cnt=%0d full=%0d expected 9,1", move_count, board_full);
    end
    do_request(4'd0, 1'b1, code, lat, extra);
    checks++;
    if (code !== 3'd2) begin
      errors++;
      $display("FAIL fill_occupied: code=%0d expected 2", code);
    end
    do_request(4'd12, 1'b1, code, lat, extra);
    checks++;
    if (code !== 3'd1 || move_count !== 4'd9) begin
      errors++;
      $display("FAIL fill_range: code=%0d cnt=%0d expected 1,9", code, move_count);
    end
  endtask

  task automatic test_back_to_back();
    int perm [9];
    int acc, pulses, last, tmp, j;
    logic adv;
    do_reset();
    for (int i = 0; i < 9; i++) perm[i] = i;
    for (int i = 8; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    acc = 0; pulses = 0; last = -1; adv = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_sel = 4'(perm[0]);
    req_player = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (t > 0) @(negedge clk);
      if (resp_valid) begin
        pulses++;
        checks++;
        if (resp_code !== 3'd0) begin
          errors++;
          $display("FAIL b2b_code: got %0d expected 0 at t=%0d", resp_code, t);
        end
      end
      if (adv) begin
        if (acc == 5) req_valid = 1'b0;
        else begin
          req_sel = 4'(perm[acc]);
          req_player = 1'(acc % 2);
        end
        adv = 1'b0;
      end
      if (req_valid && req_ready) begin
        if (last >= 0) begin
          checks++;
          if (t - last != 4) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles expected 4", t - last);
          end
        end
        last = t;
        model_apply(perm[acc], acc % 2);
        acc++;
        adv = 1'b1;
      end
    end
    checks++;
    if (acc != 5 || pulses != 5 || move_count !== 4'd5) begin
      errors++;
      $display("FAIL b2b_counts: accepts=%0d pulses=%0d cnt=%0d expected 5,5,5", acc, pulses, move_count);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (dut_cell(i) !== WIDTH'(mb[i])) begin
        errors++;
        $display("FAIL b2b_cell%0d: got %0d expected %0d", i + 1, dut_cell(i), mb[i]);
      end
    end
  endtask

  task automatic test_clear_abort();
    int seen;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      @(negedge clk);
      req_valid = 1'b1;
      req_sel = 4'd2;
      req_player = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      if (pass == 0) begin
        @(negedge clk);
        clear = 1'b1;
      end else begin
        rst_n = 1'b0;
      end
      @(negedge clk);
      clear = 1'b0;
      rst_n = 1'b1;
      checks++;
      if (cell3 !== '0 || resp_valid !== 1'b0 || req_ready !== 1'b1 || move_count !== 4'd0) begin
        errors++;
        $display("FAIL abort%0d: cell3=%0d rv=%0d rdy=%0d cnt=%0d expected 0,0,1,0",
                 pass, cell3, resp_valid, req_ready, move_count);
      end
      seen = 0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (resp_valid) seen++;
      end
      checks++;
      if (seen != 0 || cell3 !== '0) begin
        errors++;
        $display("FAIL abort%0d_quiet: pulses=%0d cell3=%0d expected 0,0", pass, seen, cell3);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] code; int lat; logic extra;
    int sel, pl, exp;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 11));
      pl = ($urandom_range(0, 3) == 0) ? 1 - mturn : mturn;
      exp = model_code(sel, pl);
      do_request(4'(sel), 1'(pl), code, lat, extra);
      if (exp == 0) model_apply(sel, pl);
      checks++;
      if (code !== 3'(exp) || lat != ((exp == 0) ? 3 : 2) || extra !== 1'b0) begin
        errors++;
        $display("FAIL rand_resp n=%0d sel=%0d pl=%0d: code=%0d lat=%0d extra=%0d expected %0d lat %0d",
                 n, sel, pl, code, lat, extra, exp, (exp == 0) ? 3 : 2);
      end
      checks++;
      if (move_count !== 4'(mcount) || turn !== 1'(mturn) || board_full !== (mcount == 9)) begin
        errors++;
        $display("FAIL rand_ctrl n=%0d: cnt=%0d turn=%0d full=%0d expected %0d,%0d,%0d",
                 n, move_count, turn, board_full, mcount, mturn, mcount == 9);
      end
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (dut_cell(i) !== WIDTH'(mb[i])) begin
          errors++;
          $display("FAIL rand_cell%0d n=%0d: got %0d expected %0d", i + 1, n, dut_cell(i), mb[i]);
        end
      end
      if (mcount == 9) do_reset();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_center();
    test_errors();
    test_fill();
    test_back_to_back();
    test_clear_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
